flt_to_fix_conv: RTL and testbench
==================================

# flt_to_fix_conv

Sequential converter from IEEE-754 half-precision float to signed fixed-point 8.8; the inverse of the fixed(8.8)→float16 conversion exercised in program 1. It sits beside the program cores as a hardware golden model for the float→fixed program. A bench drives an operand and pulses `start`, then compares this block's result against the CPU's memory image once `ack` rises. It uses a shift-one-bit-per-cycle datapath with a start/ack handshake.

## Interface
- No parameters; widths are fixed by the formats.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE or DONE.
- `flt_in` in 16: float16 operand {sign, exp[4:0] bias 15, mant[9:0]}; captured on the accepting edge.
- `fix_out` out 16: two's-complement 8.8 result; valid while `ack`=1.
- `ack` out 1: conversion complete; level, held.
- `busy` out 1: high in CLASSIFY/SHIFT/FINISH.

## Operation
- States: IDLE, CLASSIFY, SHIFT, FINISH, DONE.
- IDLE/DONE with `start`=1:
  - Capture `flt_in` and go to CLASSIFY.
  - `ack` drops on that edge.
- CLASSIFY: let e = exp and mag = {1,mant} (17-bit register).
  - e=0 (zero, denormal): result 0x0000.
  - e=31, mant≠0 (NaN): result 0x0000.
  - e=31, mant=0 (±inf): saturate.
  - e≥22: saturate.
  - Saturation gives 0x7FFF for positive inputs and 0x8000 for negative inputs.
  - The four cases above go straight to FINISH with N=0.
  - 17≤e≤21: load count N=e−17, direction left.
  - 1≤e≤16: load count N=17−e, direction right.
  - Clear guard and sticky.
  - Go to SHIFT if N>0, else FINISH.
- SHIFT: one bit per cycle, decrementing N; go to FINISH when N reaches 1.
  - Right shift: sticky |= guard, then guard ← mag[0], then mag >>= 1.
  - Left shift: mag <<= 1.
- FINISH:
  - Optional rounding (see Configuration).
  - If magnitude > 0x7FFF: positive inputs saturate to 0x7FFF; negative inputs give 0x8000 when magnitude = 0x8000 exactly, else 0x8000.
  - Otherwise apply the sign by two's-complement negation.
  - Register the result to `fix_out`, set `ack`, go to DONE.
- DONE:
  - Hold `fix_out` and `ack` until the next accepted `start` or `reset`.
  - `start` held high across several cycles starts exactly one conversion per accept. It re-triggers only if still high on returning to DONE.
- `start` is ignored while `busy`=1, and `flt_in` changes during busy have no effect.
- Negative zero (0x8000 input) gives 0x0000.

## Timing
- Reset values: state IDLE, `fix_out`=0x0000, `ack`=0, `busy`=0, internal regs 0.
- `reset` overrides everything, including mid-conversion. The next edge after reset deasserts accepts `start`.
- Latency: with the accepting edge counted as edge 1, `ack` and `fix_out` are valid after edge 3+N.
- Range: N ≤ 16, so worst case is e=1 with ack after edge 19.
- `busy` is high from edge 1 through edge 2+N; `ack` and `busy` are never both high.

## Configuration
- `FLT2FIX_ROUND_EN` defined:
  - Round to nearest, ties to even, on the magnitude in FINISH.
  - Increment when guard & (sticky | mag[0]).
  - The carry may produce 0x8000, which then saturates per sign as above.
- Undefined:
  - Truncate the magnitude (round toward zero); guard and sticky are ignored.
  - No extra cycles either way.

## Test plan
- 0x3C00 (1.0) → `fix_out`=0x0100.
  - `ack` after edge 5 (N=2).
  - `busy` is high exactly on edges 1–4.
- 0xC600 (−6.0) → 0xFA00, `ack` after edge 3 (N=0).
  - 0x57FF → 0x7FF0.
  - 0x1C00 (1/256) → 0x0001, ack after edge 13.
- Saturation and specials:
  - 0x5800 → 0x7FFF; 0xD800 → 0x8000.
  - 0x7C00 → 0x7FFF; 0xFC00 → 0x8000.
  - 0x7E00 → 0x0000; 0x0000 / 0x8000 / 0x03FF → 0x0000.
  - Each has `ack` after edge 3.
- Rounding:
  - 0x1E00 (1.5 LSB) → 0x0002 with `FLT2FIX_ROUND_EN`, 0x0001 without.
  - 0x1A00 (0.75 LSB) → 0x0001 / 0x0000.
  - 0x1800 (0.5 LSB, tie) → 0x0000 in both builds.
- Handshake:
  - `start` held high for 2 cycles on 0x3C00 → exactly one conversion.
  - `start` during SHIFT with 0x4000 on `flt_in` → ignored; result still 0x0100.
  - New `start` in DONE → `ack` low on the next edge, new result as specified.
- Reset mid-SHIFT on 0x1C00 → next edge: state IDLE, `ack`=0, `busy`=0, `fix_out`=0x0000. A following 0x3C00 request converts normally.
- Random sweep: ≥100 random float16 operands compared against a bench model of the rules above, in both macro builds.

Source files
------------

// File: rtl/flt_to_fix_conv.sv
// -----------------------------------------------------------------------------
// flt_to_fix_conv
//
// Sequential converter from IEEE-754 half precision (float16) to signed
// two's-complement fixed point 8.8. The magnitude is aligned by shifting it
// one bit per cycle, so a conversion takes 3+N edges from the accepting edge.
// N is the alignment distance: 0..4 to the left, or 1..16 to the right.
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset    in   1  synchronous, active-high reset
//   start    in   1  conversion request, honoured only in IDLE or DONE
//   flt_in   in  16  float16 operand {sign, exp[4:0] (bias 15), mant[9:0]}
//   fix_out  out 16  8.8 result, valid while ack is high
//   ack      out  1  conversion complete (level, held until next accept)
//   busy     out  1  conversion in progress (CLASSIFY/SHIFT/FINISH)
//
// Build option:
//   FLT2FIX_ROUND_EN  defined   -> round to nearest, ties to even
//                     undefined -> truncate toward zero
// -----------------------------------------------------------------------------
module flt_to_fix_conv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] flt_in,
  output logic [15:0] fix_out,
  output logic        ack,
  output logic        busy
);

`ifdef FLT2FIX_ROUND_EN
  localparam logic RoundEn = 1'b1;
`else
  localparam logic RoundEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_SHIFT,
    S_FINISH,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [15:0] flt_q;     // operand captured on the accepting edge
  logic [16:0] mag_q;     // {1,mant} aligned to 8.8 units; bit 16 flags overflow
  logic [4:0]  cnt_q;     // remaining shift steps
  logic        left_q;    // shift direction
  logic        guard_q;   // first bit shifted out to the right
  logic        sticky_q;  // OR of every bit shifted out below the guard
  logic [15:0] fix_q;
  logic        ack_q;
  logic        busy_q;

  // Classification of the captured operand.
  logic [4:0]  exp_w;
  logic [9:0]  mant_w;
  logic [16:0] cls_mag_d;
  logic [4:0]  cls_cnt_d;
  logic        cls_left_d;

  assign exp_w  = flt_q[14:10];
  assign mant_w = flt_q[9:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cls_mag_d  = {6'd0, 1'b1, mant_w};
    cls_cnt_d  = 5'd0;
    cls_left_d = 1'b0;
    if (exp_w == 5'd0) begin
      cls_mag_d = 17'd0;                      // zero and denormals
    end else if (exp_w == 5'd31 && mant_w != 10'd0) begin
      cls_mag_d = 17'd0;                      // NaN
    end else if (exp_w >= 5'd22) begin
      cls_mag_d = 17'h10000;                  // inf or out of range: forces saturation
    end else if (exp_w >= 5'd17) begin
      cls_cnt_d  = exp_w - 5'd17;
      cls_left_d = 1'b1;
    end else begin
      cls_cnt_d  = 5'd17 - exp_w;
    end
  end

  // Rounding, saturation and sign application for FINISH.
  logic        round_inc;
  logic [16:0] mag_rnd;
  logic [15:0] fix_d;

  always_comb begin
    round_inc = guard_q & (sticky_q | mag_q[0]);
    mag_rnd   = mag_q + {16'd0, RoundEn & round_inc};
    if (mag_rnd > 17'h07FFF) begin
      fix_d = flt_q[15] ? 16'h8000 : 16'h7FFF;
    end else if (flt_q[15]) begin
      fix_d = ~mag_rnd[15:0] + 16'd1;
    end else begin
      fix_d = mag_rnd[15:0];
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      flt_q    <= 16'd0;
      mag_q    <= 17'd0;
      cnt_q    <= 5'd0;
      left_q   <= 1'b0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      fix_q    <= 16'd0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            flt_q   <= flt_in;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          mag_q    <= cls_mag_d;
          cnt_q    <= cls_cnt_d;
          left_q   <= cls_left_d;
          guard_q  <= 1'b0;
          sticky_q <= 1'b0;
          state_q  <= (cls_cnt_d != 5'd0) ? S_SHIFT : S_FINISH;
        end
        S_SHIFT: begin
          if (left_q) begin
            mag_q <= {mag_q[15:0], 1'b0};
          end else begin
            sticky_q <= sticky_q | guard_q;
            guard_q  <= mag_q[0];
            mag_q    <= {1'b0, mag_q[16:1]};
          end
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          fix_q   <= fix_d;
          ack_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fix_out = fix_q;
  assign ack     = ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_flt_to_fix_conv.sv
// -----------------------------------------------------------------------------
// tb_flt_to_fix_conv
//
// Directed vectors, handshake and reset scenarios, then a random sweep checked
// against an arithmetic model of float16 -> 8.8 conversion.
// -----------------------------------------------------------------------------
module tb_flt_to_fix_conv;

`ifdef FLT2FIX_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] flt_in;
  logic [15:0] fix_out;
  logic        ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  flt_to_fix_conv dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .flt_in  (flt_in),
    .fix_out (fix_out),
    .ack     (ack),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Value of the float scaled by 256, reduced to 8.8 by the conversion rules.
  function automatic logic [15:0] ref_fix(input logic [15:0] f);
    int e, m, k, mag, rem, half;
    e = int'(f[14:10]);
    m = 1024 + int'(f[9:0]);
    if (e == 0 || (e == 31 && f[9:0] != 10'd0)) return 16'h0000;
    if (e >= 22) begin
      mag = 32768;
    end else if (e >= 17) begin
      mag = m << (e - 17);
    end else begin
      k    = 17 - e;
      mag  = m >> k;
      rem  = m - (mag << k);
      half = 1 << (k - 1);
      if (RoundEn && (rem > half || (rem == half && (mag % 2) == 1))) mag++;
    end
    if (mag > 32767) return f[15] ? 16'h8000 : 16'h7FFF;
    return f[15] ? 16'(-mag) : 16'(mag);
  endfunction

  // Alignment distance that sets the latency (ack after edge 3+N).
  function automatic int ref_n(input logic [15:0] f);
    int e;
    e = int'(f[14:10]);
    if (e == 0 || e >= 22) return 0;
    if (e >= 17) return e - 17;
    return 17 - e;
  endfunction

  // One full request: accept, wait for ack (bounded), check result,
  // latency and that busy/ack behave as complements throughout.
  task automatic convert(input string tag, input logic [15:0] f,
                         input logic [15:0] exp_fix, input int exp_n);
    int edges;
    bit hs_ok;
    flt_in = f;
    start  = 1'b1;
    tick();
    edges  = 1;
    start  = 1'b0;
    flt_in = 16'($urandom);
    hs_ok  = (busy === 1'b1) && (ack === 1'b0);
    while (ack !== 1'b1 && edges < 40) begin
      tick();
      edges++;
      if (ack !== 1'b1 && busy !== 1'b1) hs_ok = 1'b0;
      if (ack === 1'b1 && busy !== 1'b0) hs_ok = 1'b0;
    end
    check({tag, " result"}, 32'(fix_out), 32'(exp_fix));
    check({tag, " latency"}, 32'(edges), 32'(3 + exp_n));
    check({tag, " busy"}, 32'(hs_ok), 32'd1);
  endtask

  typedef struct {
    logic [15:0] f;
    logic [15:0] trunc;
    logic [15:0] rnd;
    int          n;
  } vec_t;

  vec_t vecs[15] = '{
    '{16'h3C00, 16'h0100, 16'h0100,  2},
    '{16'hC600, 16'hFA00, 16'hFA00,  0},
    '{16'h57FF, 16'h7FF0, 16'h7FF0,  4},
    '{16'h1C00, 16'h0001, 16'h0001, 10},
    '{16'h5800, 16'h7FFF, 16'h7FFF,  0},
    '{16'hD800, 16'h8000, 16'h8000,  0},
    '{16'h7C00, 16'h7FFF, 16'h7FFF,  0},
    '{16'hFC00, 16'h8000, 16'h8000,  0},
    '{16'h7E00, 16'h0000, 16'h0000,  0},
    '{16'h0000, 16'h0000, 16'h0000,  0},
    '{16'h8000, 16'h0000, 16'h0000,  0},
    '{16'h03FF, 16'h0000, 16'h0000,  0},
    '{16'h1E00, 16'h0001, 16'h0002, 10},
    '{16'h1A00, 16'h0000, 16'h0001, 11},
    '{16'h1800, 16'h0000, 16'h0000, 11}
  };

  initial begin
    int          edges;
    logic [15:0] rf;

    reset  = 1'b1;
    start  = 1'b0;
    flt_in = 16'h0000;
    repeat (2) tick();
    check("reset fix_out", 32'(fix_out), 32'h0000);
    check("reset ack/busy", 32'({ack, busy}), 32'd0);
    reset = 1'b0;

    // Directed vectors from the test plan.
    foreach (vecs[i]) begin
      convert($sformatf("vec %04h", vecs[i].f), vecs[i].f,
              RoundEn ? vecs[i].rnd : vecs[i].trunc, vecs[i].n);
    end

    // start held for two cycles: exactly one conversion.
    flt_in = 16'h3C00;
    start  = 1'b1;
    tick();
    edges = 1;
    tick();
    edges = 2;
    start = 1'b0;
    while (ack !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    check("held result", 32'(fix_out), 32'h0100);
    check("held latency", 32'(edges), 32'd5);
    repeat (4) tick();
    check("held single conversion", 32'({ack, busy}), 32'b10);

    // start and a new operand during SHIFT are ignored.
    flt_in = 16'h3C00;
    start  = 1'b1;
    tick();
    edges = 1;
    start = 1'b0;
    tick();
    edges++;
    flt_in = 16'h4000;
    start  = 1'b1;
    tick();
    edges++;
    start = 1'b0;
    while (ack !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    check("shift-start result", 32'(fix_out), 32'h0100);
    check("shift-start latency", 32'(edges), 32'd5);

    // New request from DONE: ack drops on the accepting edge.
    flt_in = 16'hC600;
    start  = 1'b1;
    tick();
    edges = 1;
    start = 1'b0;
    check("done restart ack/busy", 32'({ack, busy}), 32'b01);
    while (ack !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    check("done restart result", 32'(fix_out), 32'hFA00);
    check("done restart latency", 32'(edges), 32'd3);

    // Reset in the middle of a long right shift.
    flt_in = 16'h1C00;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("mid-shift busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("mid-reset fix_out", 32'(fix_out), 32'h0000);
    check("mid-reset ack/busy", 32'({ack, busy}), 32'd0);
    reset = 1'b0;
    convert("post-reset", 16'h3C00, 16'h0100, 2);

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 120; i++) begin
      rf = 16'($urandom_range(0, 65535));
      convert($sformatf("rand %04h", rf), rf, ref_fix(rf), ref_n(rf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
